// File: rtl/seq_restoring_divider_if.sv
// Handshake bus for seq_restoring_divider.
// The master side supplies operands and consumes results. The slave side is the divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider that produces one quotient bit per clock.
// Operands enter through a valid/ready handshake, and results leave through another one.
// A zero divisor bypasses the iteration and raises div_by_zero.
// Optional macro SEQ_DIV_SIGNED_EN selects two's-complement operands. The magnitudes go
// through the same unsigned core, and the signs are fixed up on entry to DONE.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_restoring_divider_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   r_q, q_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quot_q, rem_q;
  logic               dbz_q, out_valid_q, busy_q;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   r_d, q_d;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;

  // Shift {R,Q} left by one bit and trial-subtract B in WIDTH+1 bits.
  // A set MSB in the trial result means the difference went negative, so R is restored.
  assign trial = {r_q, q_q[WIDTH-1]} - {1'b0, b_q};
  assign r_d   = trial[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef SEQ_DIV_SIGNED_EN
  logic sign_q_q, sign_r_q;
  // |MIN| stays MIN as a bit pattern, which the unsigned core reads correctly as 2^(WIDTH-1).
  assign a_mag    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign quot_fix = sign_q_q ? -q_d : q_d;
  assign rem_fix  = sign_r_q ? -r_d : r_d;
`else
  assign a_mag    = bus.dividend;
  assign b_mag    = bus.divisor;
  assign quot_fix = q_d;
  assign rem_fix  = r_d;
`endif

  // Control FSM and datapath. The result registers change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              quot_q      <= '1;
              rem_q       <= bus.dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              r_q     <= '0;
              q_q     <= a_mag;
              b_q     <= b_mag;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= CALC;
            end
`ifdef SEQ_DIV_SIGNED_EN
            sign_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r_q <= bus.dividend[WIDTH-1];
`endif
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quot_q      <= quot_fix;
            rem_q       <= rem_fix;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;
endmodule
